// File: rtl/float_argmax_seq.sv
// Scans a vector of IEEE-754 words from a shared memory, one read per element,
// and keeps the running maximum, its index, and NaN/found status.
module float_argmax_seq #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_val,
    output logic [ADDR_W-1:0] max_idx,
    output logic              found,
    output logic              nan_seen
);

    localparam int MANT_W = DATA_W - 1 - EXP_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_max_val;
    logic [ADDR_W-1:0] r_max_idx;
    logic              r_found;
    logic              r_nan_seen;

    logic              w_data_nan;
    logic              w_data_gt;
    logic              w_last;

    function automatic logic is_nan(input logic [DATA_W-1:0] v);
        return (&v[DATA_W-2 -: EXP_W]) && (|v[MANT_W-1:0]);
    endfunction

    // Sign-magnitude ordering: negatives compare with reversed magnitude, so +0 > -0.
    function automatic logic float_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic res;
        if (is_nan(a) || is_nan(b))
            res = 1'b0;
        else if (a[DATA_W-1] && b[DATA_W-1])
            res = a[DATA_W-2:0] < b[DATA_W-2:0];
        else if (a[DATA_W-1] == b[DATA_W-1])
            res = a[DATA_W-2:0] > b[DATA_W-2:0];
        else
            res = ~a[DATA_W-1];
        return res;
    endfunction

    assign w_data_nan = is_nan(mem_rdata);
    assign w_data_gt  = float_gt(mem_rdata, r_max_val);
    assign w_last     = (r_cnt == r_len - ADDR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_max_val  <= '0;
            r_max_idx  <= '0;
            r_found    <= 1'b0;
            r_nan_seen <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_base     <= base;
                        r_len      <= len;
                        r_cnt      <= '0;
                        r_max_val  <= '0;
                        r_max_idx  <= '0;
                        r_found    <= 1'b0;
                        r_nan_seen <= 1'b0;
                        r_state    <= (len == '0) ? S_FIN : S_REQ;
                    end
                end
                S_REQ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        // Ties are not strictly greater, so the earlier index survives.
                        if (w_data_nan) begin
                            r_nan_seen <= 1'b1;
                        end else if (!r_found || w_data_gt) begin
                            r_max_val <= mem_rdata;
                            r_max_idx <= r_cnt;
                            r_found   <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= S_FIN;
                        end else begin
                            r_cnt   <= r_cnt + ADDR_W'(1);
                            r_state <= S_REQ;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req  = (r_state == S_REQ);
    assign mem_addr = r_base + r_cnt;
    assign busy     = (r_state == S_REQ) || (r_state == S_WAIT);
    assign done     = (r_state == S_FIN);
    assign max_val  = r_max_val;
    assign max_idx  = r_max_idx;
    assign found    = r_found;
    assign nan_seen = r_nan_seen;

endmodule

// File: tb/tb_float_argmax_seq.sv
// Randomized bench for float_argmax_seq: a memory responder with configurable
// read latency and an ordering-key reference model for the expected maximum.
module tb_float_argmax_seq;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW-1:0] len = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rvalid = 1'b0;
    logic          busy;
    logic          done;
    logic [DW-1:0] max_val;
    logic [AW-1:0] max_idx;
    logic          found;
    logic          nan_seen;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            fixed_delay = 1;
    bit            pend = 1'b0;
    int            pend_cnt = 0;
    logic [DW-1:0] pend_data = '0;
    int            dup_req = 0;
    int            done_cnt = 0;
    logic [AW-1:0] addrs[$];
    logic [DW-1:0] mem[0:1023];

    float_argmax_seq dut (
        .clk(clk), .rst(rst), .run(run), .base(base), .len(len),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .busy(busy), .done(done), .max_val(max_val),
        .max_idx(max_idx), .found(found), .nan_seen(nan_seen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: sees a request mid-cycle, returns data fixed_delay cycles later
    // (fixed_delay==0 picks 1..5 at random); garbage on rdata whenever rvalid is low.
    always @(negedge clk) begin
        if (mem_rvalid) begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
                pend       = 1'b0;
            end
        end
        if (mem_req) begin
            if (pend) dup_req++;
            addrs.push_back(mem_addr);
            pend      = 1'b1;
            pend_cnt  = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 5));
            pend_data = mem[mem_addr];
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    function automatic bit ref_is_nan(input logic [31:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
    endfunction

    // Total-order key: larger key means greater float; -0 sits just below +0.
    function automatic longint ref_key(input logic [31:0] w);
        longint mag;
        mag = longint'({33'd0, w[30:0]});
        return w[31] ? (-mag - 1) : mag;
    endfunction

    function automatic logic [31:0] rand_elem();
        logic [31:0] w;
        logic        s;
        s = 1'($urandom);
        case ($urandom_range(0, 7))
            0: w = {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
            1: w = {s, 31'd0};
            2: w = {s, 8'hFF, 23'd0};
            3: w = 32'h3F800000;
            4: w = 32'hC0000000;
            default: w = $urandom;
        endcase
        return w;
    endfunction

    task automatic run_scan(input string tag, input logic [AW-1:0] b, input int l, input bit spam);
        int          lat;
        int          t0;
        int          guard;
        int          dc0;
        bit          e_found;
        bit          e_nan;
        logic [31:0] e_val;
        int          e_idx;
        logic [AW-1:0] a;
        logic [31:0] w;

        addrs.delete();
        dup_req = 0;
        dc0 = done_cnt;
        base = b;
        len = AW'(l);
        run = 1'b1;
        t0 = cyc;
        tick();
        run = 1'b0;
        guard = 0;
        while (!done && guard < 2000) begin
            if (spam) begin
                run  = 1'($urandom);
                base = AW'($urandom);
                len  = AW'($urandom);
            end
            tick();
            guard++;
        end
        lat = cyc - t0;
        run = 1'b0;
        check({tag, "_done_seen"}, 64'(done), 64'd1);

        e_found = 1'b0; e_nan = 1'b0; e_val = '0; e_idx = 0;
        for (int i = 0; i < l; i++) begin
            a = b + AW'(i);
            w = mem[a];
            if (ref_is_nan(w)) e_nan = 1'b1;
            else if (!e_found || ref_key(w) > ref_key(e_val)) begin
                e_val = w; e_idx = i; e_found = 1'b1;
            end
        end
        if (fixed_delay == 1) check({tag, "_latency"}, 64'(lat), 64'(2 * l + 1));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_max_val"}, 64'(max_val), 64'(e_val));
        check({tag, "_max_idx"}, 64'(max_idx), 64'(e_idx));
        check({tag, "_found"}, 64'(found), 64'(e_found));
        check({tag, "_nan_seen"}, 64'(nan_seen), 64'(e_nan));
        check({tag, "_req_count"}, 64'(addrs.size()), 64'(l));
        for (int i = 0; i < l && i < addrs.size(); i++)
            check({tag, "_addr"}, 64'(addrs[i]), 64'(AW'(b + AW'(i))));
        check({tag, "_dup_req"}, 64'(dup_req), 64'd0);
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        tick(); tick(); tick();
        check({tag, "_no_extra_req"}, 64'(addrs.size()), 64'(l));
        check({tag, "_one_done"}, 64'(done_cnt - dc0), 64'd1);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_max_val"}, 64'(max_val), 64'd0);
        check({tag, "_max_idx"}, 64'(max_idx), 64'd0);
        check({tag, "_found"}, 64'(found), 64'd0);
        check({tag, "_nan_seen"}, 64'(nan_seen), 64'd0);
    endtask

    initial begin
        int guard;
        int dc;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        tick(); tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Mixed vector with a 1-cycle memory.
        mem[10'h10] = 32'h3F800000; mem[10'h11] = 32'h40400000;
        mem[10'h12] = 32'hC0000000; mem[10'h13] = 32'h40000000;
        run_scan("mixed", 10'h10, 4, 1'b0);
        check("mixed_const_val", 64'(max_val), 64'h40400000);
        check("mixed_const_idx", 64'(max_idx), 64'd1);

        mem[10'h20] = 32'hC0400000; mem[10'h21] = 32'hBF800000; mem[10'h22] = 32'hC0000000;
        run_scan("negs", 10'h20, 3, 1'b0);
        check("negs_const_val", 64'(max_val), 64'hBF800000);

        mem[10'h30] = 32'h7FC00000; mem[10'h31] = 32'h00000000;
        mem[10'h32] = 32'h80000000; mem[10'h33] = 32'h00000000;
        run_scan("nan_zero", 10'h30, 4, 1'b0);
        check("nan_zero_const_idx", 64'(max_idx), 64'd1);

        run_scan("len0", 10'h40, 0, 1'b0);

        mem[10'h50] = 32'h7FC00000; mem[10'h51] = 32'hFF800001;
        run_scan("all_nan", 10'h50, 2, 1'b0);
        check("all_nan_const_found", 64'(found), 64'd0);

        // Address wrap with random latency and run pulses while busy.
        fixed_delay = 0;
        for (int i = 0; i < 3; i++) mem[AW'(10'h3FE + AW'(i))] = rand_elem();
        run_scan("wrap", 10'h3FE, 3, 1'b1);
        if (addrs.size() == 3) check("wrap_addr2", 64'(addrs[2]), 64'd0);

        for (int t = 0; t < 25; t++) begin
            logic [AW-1:0] b;
            int            l;
            b = AW'($urandom);
            l = int'($urandom_range(1, 12));
            for (int i = 0; i < l; i++) mem[AW'(b + AW'(i))] = rand_elem();
            run_scan("rand", b, l, 1'($urandom));
        end

        // Reset while waiting on element 2; its late rvalid must be ignored.
        fixed_delay = 4;
        for (int i = 0; i < 4; i++) mem[10'h100 + i] = rand_elem();
        addrs.delete();
        base = 10'h100; len = 10'd4; run = 1'b1;
        tick();
        run = 1'b0;
        guard = 0;
        while (addrs.size() < 3 && guard < 200) begin
            tick();
            guard++;
        end
        check("rstwait_reached", 64'(addrs.size()), 64'd3);
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        dc = done_cnt;
        for (int i = 0; i < 8; i++) tick();
        check("midrst_no_done", 64'(done_cnt - dc), 64'd0);
        check("midrst_found", 64'(found), 64'd0);
        check("midrst_max_val", 64'(max_val), 64'd0);
        check("midrst_no_req", 64'(addrs.size()), 64'd3);
        fixed_delay = 1;
        run_scan("after_rst", 10'h100, 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
